// File: rtl/zbb_pkg.sv
// Shared encodings and constants for the Zbb bit-count unit.
package zbb_pkg;

   typedef enum logic [1:0] {
      OP_CLZ  = 2'b00,
      OP_CTZ  = 2'b01,
      OP_CPOP = 2'b10,
      OP_RSVD = 2'b11
   } zbb_op_e;

   localparam int WORD_RANGE = 32;

endpackage

// File: rtl/zbb_bitcount_unit_if.sv
// Issue/writeback handshake bundle for the Zbb bit-count unit; signal suffixes are from the unit's side.
interface zbb_bitcount_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [1:0]       op_i;
   logic             word_i;
   logic [XLEN-1:0]  operand_i;
   logic [TAG_W-1:0] tag_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  result_o;
   logic [TAG_W-1:0] tag_o;
   logic             illegal_o;

   modport master (
      output flush_i, in_valid_i, op_i, word_i, operand_i, tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, tag_o, illegal_o
   );

   modport slave (
      input  flush_i, in_valid_i, op_i, word_i, operand_i, tag_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, tag_o, illegal_o
   );
endinterface

// File: rtl/zbb_lzc.sv
// Combinational leading-zero counter built by recursive halving; WIDTH must be a power of two.
module zbb_lzc #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0]         data_i,
   output logic [$clog2(WIDTH):0]   count_o
);
   if (WIDTH == 1) begin : g_leaf
      assign count_o = ~data_i;
   end else begin : g_split
      localparam int HALF = WIDTH / 2;
      localparam int CW   = $clog2(HALF) + 1;
      logic [CW-1:0] hi_cnt;
      logic [CW-1:0] lo_cnt;

      zbb_lzc #(.WIDTH(HALF)) u_hi (.data_i(data_i[WIDTH-1:HALF]), .count_o(hi_cnt));
      zbb_lzc #(.WIDTH(HALF)) u_lo (.data_i(data_i[HALF-1:0]),     .count_o(lo_cnt));

      // The MSB of a half count is set only when that half is all zeros.
      assign count_o = hi_cnt[CW-1] ? ((CW+1)'(HALF) + {1'b0, lo_cnt}) : {1'b0, hi_cnt};
   end
endmodule

// File: rtl/zbb_bitcount_unit.sv
// Two-stage CLZ/CTZ/CPOP execution unit with tag pass-through and flush.
// Popcount datapath is built only when ZBB_BITCOUNT_CPOP_EN is defined.
module zbb_bitcount_unit
   import zbb_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input logic                clk,
   input logic                rst,
   zbb_bitcount_unit_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   genvar gi;

   zbb_op_e          op_in;
   logic             s2_can_load;
   logic             in_ready;
   logic             accept;
   logic [XLEN-1:0]  rev_full;
   logic [XLEN-1:0]  word_clz_vec;
   logic [XLEN-1:0]  word_ctz_vec;
   logic [XLEN-1:0]  vec_d;
   logic             illegal_d;

   logic             s1_valid_q;
   logic             s1_illegal_q;
   logic [XLEN-1:0]  s1_vec_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic             out_valid_q;
   logic [XLEN-1:0]  result_q;
   logic [TAG_W-1:0] tag_q;
   logic             illegal_q;

   logic [CNT_W-1:0] lzc_cnt;
   logic [CNT_W-1:0] count_d;
   logic [XLEN-1:0]  result_d;

   assign op_in       = zbb_op_e'(bus.op_i);
   assign s2_can_load = !out_valid_q || bus.out_ready_i;
   assign in_ready    = !bus.flush_i && (!s1_valid_q || s2_can_load);
   assign accept      = bus.in_valid_i && in_ready;

   for (gi = 0; gi < XLEN; gi++) begin : g_rev_full
      assign rev_full[gi] = bus.operand_i[XLEN-1-gi];
   end

   // Word mode pads the low half with ones so the full-width LZC saturates at 32.
   if (XLEN > WORD_RANGE) begin : g_word
      logic [WORD_RANGE-1:0] rev_word;
      for (gi = 0; gi < WORD_RANGE; gi++) begin : g_rev_word
         assign rev_word[gi] = bus.operand_i[WORD_RANGE-1-gi];
      end
      assign word_clz_vec = {bus.operand_i[WORD_RANGE-1:0], {(XLEN-WORD_RANGE){1'b1}}};
      assign word_ctz_vec = {rev_word, {(XLEN-WORD_RANGE){1'b1}}};
   end else begin : g_no_word
      assign word_clz_vec = '0;
      assign word_ctz_vec = '0;
   end

`ifdef ZBB_BITCOUNT_CPOP_EN
   logic [XLEN-1:0]  cpop_src;
   logic [CNT_W-1:0] pop_cnt;
   logic             s1_pop_q;

   assign cpop_src = bus.word_i ? XLEN'(bus.operand_i[WORD_RANGE-1:0]) : bus.operand_i;

   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < XLEN; i++) begin
         pop_cnt = pop_cnt + CNT_W'(s1_vec_q[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_pop_q <= 1'b0;
      end else if (accept) begin
         s1_pop_q <= (op_in == OP_CPOP);
      end
   end

   assign count_d = s1_pop_q ? pop_cnt : lzc_cnt;
`else
   assign count_d = lzc_cnt;
`endif

   always_comb begin
      vec_d     = '0;
      illegal_d = (op_in == OP_RSVD) || (bus.word_i && (XLEN == WORD_RANGE));
`ifndef ZBB_BITCOUNT_CPOP_EN
      illegal_d = illegal_d || (op_in == OP_CPOP);
`endif
      case (op_in)
         OP_CLZ:  vec_d = bus.word_i ? word_clz_vec : bus.operand_i;
         OP_CTZ:  vec_d = bus.word_i ? word_ctz_vec : rev_full;
`ifdef ZBB_BITCOUNT_CPOP_EN
         OP_CPOP: vec_d = cpop_src;
`endif
         default: vec_d = '0;
      endcase
   end

   zbb_lzc #(.WIDTH(XLEN)) u_lzc (.data_i(s1_vec_q), .count_o(lzc_cnt));

   assign result_d = s1_illegal_q ? '0 : XLEN'(count_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_illegal_q <= 1'b0;
         s1_vec_q     <= '0;
         s1_tag_q     <= '0;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         tag_q        <= '0;
         illegal_q    <= 1'b0;
      end else begin
         if (bus.flush_i) begin
            s1_valid_q <= 1'b0;
         end else if (in_ready) begin
            s1_valid_q <= bus.in_valid_i;
         end
         if (accept) begin
            s1_illegal_q <= illegal_d;
            s1_vec_q     <= vec_d;
            s1_tag_q     <= bus.tag_i;
         end
         // A transfer in the flush cycle still completes; only the valids clear.
         if (bus.flush_i) begin
            out_valid_q <= 1'b0;
         end else if (s2_can_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               result_q  <= result_d;
               tag_q     <= s1_tag_q;
               illegal_q <= s1_illegal_q;
            end
         end
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid_q;
   assign bus.result_o    = result_q;
   assign bus.tag_o       = tag_q;
   assign bus.illegal_o   = illegal_q;
endmodule
